// File: rtl/irda_fir_rx_deframer.sv
// FIR 4 Mb/s receive deframer: packs LSB-first bits into bytes, holds back the 4 CRC bytes, judges the frame at stop flag.
// Payload byte n is presented 1 cycle after the strobe completing byte n+4; there is no backpressure, so the consumer must accept every strobe.
module irda_fir_rx_deframer #(
    parameter int          MAX_BYTES   = 2050,
    parameter int          LEN_W       = 12,
    parameter logic [31:0] CRC_RESIDUE = 32'hC704DD7B
) (
    input  logic             clk,
    input  logic             wb_rst_i,
    input  logic             fir_rx4_enable,
    input  logic             rx_bit_i,
    input  logic             rx_sof_i,
    input  logic             rx_eof_i,
    input  logic             rx_abort_i,
    input  logic [31:0]      crc32_par_i,
    output logic             crc_clr_o,
    output logic             crc_din_o,
    output logic [7:0]       rx_data_o,
    output logic             rx_data_valid_o,
    output logic             rx_done_o,
    output logic             rx_crc_ok_o,
    output logic             rx_len_err_o,
    output logic             rx_abort_o,
    output logic [LEN_W-1:0] rx_len_o
);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t           state_q;
    logic             crc_clr_q;
    logic [7:0]       sr_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       dl_q [4];
    logic [2:0]       dl_cnt_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             done_q;
    logic             crc_ok_q;
    logic             len_err_q;
    logic             abort_q;
    logic [LEN_W-1:0] len_q;

    logic [7:0]       byte_d;
    logic [LEN_W:0]   total_d;
    logic             eof_err_d;

    assign byte_d    = {rx_bit_i, sr_q[7:1]};
    assign total_d   = {1'b0, len_q} + (LEN_W+1)'(dl_cnt_q) + (LEN_W+1)'(1);
    assign eof_err_d = (bit_cnt_q != 3'd0) || (dl_cnt_q < 3'd4);

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            crc_clr_q <= 1'b1;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            dl_cnt_q  <= '0;
            for (int i = 0; i < 4; i++) dl_q[i] <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            crc_ok_q  <= 1'b0;
            len_err_q <= 1'b0;
            abort_q   <= 1'b0;
            len_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (state_q == RECV && rx_abort_i) begin
                state_q   <= DONE;
                crc_clr_q <= 1'b1;
                done_q    <= 1'b1;
                abort_q   <= 1'b1;
                crc_ok_q  <= 1'b0;
                len_err_q <= 1'b0;
            end else if (state_q == RECV && rx_eof_i) begin
                // The delay line now holds the CRC bytes; they are dropped here.
                state_q   <= DONE;
                crc_clr_q <= 1'b1;
                done_q    <= 1'b1;
                len_err_q <= eof_err_d;
                crc_ok_q  <= !eof_err_d && (crc32_par_i == CRC_RESIDUE);
            end else if (state_q != DONE && rx_sof_i) begin
                // A restart inside a frame pulses the checker clear for one cycle.
                state_q   <= RECV;
                crc_clr_q <= (state_q == RECV);
                bit_cnt_q <= '0;
                dl_cnt_q  <= '0;
                len_q     <= '0;
                crc_ok_q  <= 1'b0;
                len_err_q <= 1'b0;
                abort_q   <= 1'b0;
            end else if (state_q == RECV) begin
                crc_clr_q <= 1'b0;
                if (fir_rx4_enable) begin
                    sr_q      <= byte_d;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (total_d > (LEN_W+1)'(MAX_BYTES)) begin
                            state_q   <= DONE;
                            crc_clr_q <= 1'b1;
                            done_q    <= 1'b1;
                            len_err_q <= 1'b1;
                        end else if (dl_cnt_q == 3'd4) begin
                            data_q  <= dl_q[0];
                            valid_q <= 1'b1;
                            dl_q[0] <= dl_q[1];
                            dl_q[1] <= dl_q[2];
                            dl_q[2] <= dl_q[3];
                            dl_q[3] <= byte_d;
                            if (len_q != {LEN_W{1'b1}}) len_q <= len_q + 1'b1;
                        end else begin
                            dl_q[dl_cnt_q[1:0]] <= byte_d;
                            dl_cnt_q            <= dl_cnt_q + 3'd1;
                        end
                    end
                end
            end else if (state_q == DONE) begin
                state_q   <= IDLE;
                crc_clr_q <= 1'b1;
            end else begin
                crc_clr_q <= 1'b1;
            end
        end
    end

    assign crc_clr_o       = crc_clr_q;
    assign crc_din_o       = rx_bit_i;
    assign rx_data_o       = data_q;
    assign rx_data_valid_o = valid_q;
    assign rx_done_o       = done_q;
    assign rx_crc_ok_o     = crc_ok_q;
    assign rx_len_err_o    = len_err_q;
    assign rx_abort_o      = abort_q;
    assign rx_len_o        = len_q;

endmodule

// File: tb/tb_irda_fir_rx_deframer.sv
// Directed bench for irda_fir_rx_deframer: a default instance plus a MAX_BYTES=8 instance for the overlong case.
module tb_irda_fir_rx_deframer;

    logic        clk;
    logic        wb_rst_i;
    logic        fir_rx4_enable;
    logic        rx_bit_i;
    logic        rx_sof_i;
    logic        rx_eof_i;
    logic        rx_abort_i;
    logic [31:0] crc32_par_i;
    logic [31:0] crc_m;

    logic        a_clr, a_din, a_vld, a_done, a_ok, a_lerr, a_abort;
    logic [7:0]  a_data;
    logic [11:0] a_len;
    logic        b_clr, b_din, b_vld, b_done, b_ok, b_lerr, b_abort;
    logic [7:0]  b_data;
    logic [11:0] b_len;

    int checks = 0;
    int failures = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int a_done_cnt = 0;
    int b_done_cnt = 0;
    int ba, da, bb, db;
    logic [31:0] good_r;

    assign crc32_par_i = crc_m;

    irda_fir_rx_deframer u_dut (
        .clk(clk), .wb_rst_i(wb_rst_i), .fir_rx4_enable(fir_rx4_enable), .rx_bit_i(rx_bit_i),
        .rx_sof_i(rx_sof_i), .rx_eof_i(rx_eof_i), .rx_abort_i(rx_abort_i), .crc32_par_i(crc32_par_i),
        .crc_clr_o(a_clr), .crc_din_o(a_din), .rx_data_o(a_data), .rx_data_valid_o(a_vld),
        .rx_done_o(a_done), .rx_crc_ok_o(a_ok), .rx_len_err_o(a_lerr), .rx_abort_o(a_abort),
        .rx_len_o(a_len)
    );

    irda_fir_rx_deframer #(.MAX_BYTES(8)) u_dut8 (
        .clk(clk), .wb_rst_i(wb_rst_i), .fir_rx4_enable(fir_rx4_enable), .rx_bit_i(rx_bit_i),
        .rx_sof_i(rx_sof_i), .rx_eof_i(rx_eof_i), .rx_abort_i(rx_abort_i), .crc32_par_i(crc32_par_i),
        .crc_clr_o(b_clr), .crc_din_o(b_din), .rx_data_o(b_data), .rx_data_valid_o(b_vld),
        .rx_done_o(b_done), .rx_crc_ok_o(b_ok), .rx_len_err_o(b_lerr), .rx_abort_o(b_abort),
        .rx_len_o(b_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_vld) qa.push_back(a_data);
        if (b_vld) qb.push_back(b_data);
        if (a_done) a_done_cnt++;
        if (b_done) b_done_cnt++;
    end

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? 32'h04C11DB7 : 32'h0);
    endfunction

    function automatic logic [31:0] crc_of5(input logic [39:0] v);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < 8; i++) c = crc_step(c, v[39 - 8*k - 7 + i]);
        return c;
    endfunction

    function automatic logic [63:0] pack(input bit sel_b, input int base, input int n);
        logic [63:0] v = '0;
        for (int k = 0; k < n; k++) begin
            if (!sel_b && base + k < qa.size()) v = {v[55:0], qa[base + k]};
            else if (sel_b && base + k < qb.size()) v = {v[55:0], qb[base + k]};
            else v = {v[55:0], 8'hxx};
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_bit_i = b;
        fir_rx4_enable = 1'b1;
        crc_m = crc_step(crc_m, b);
        tick();
        fir_rx4_enable = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send5(input logic [39:0] v);
        for (int k = 0; k < 5; k++) send_byte(v[39 - 8*k -: 8]);
    endtask

    task automatic send_crc(input logic [31:0] r);
        for (int j = 0; j < 32; j++) send_bit(~r[31 - j]);
    endtask

    task automatic sof();
        rx_sof_i = 1'b1;
        crc_m = 32'hFFFFFFFF;
        tick();
        rx_sof_i = 1'b0;
        tick();
    endtask

    task automatic eof();
        rx_eof_i = 1'b1;
        tick();
        rx_eof_i = 1'b0;
    endtask

    initial begin
        wb_rst_i = 1'b1; fir_rx4_enable = 1'b0; rx_bit_i = 1'b0;
        rx_sof_i = 1'b0; rx_eof_i = 1'b0; rx_abort_i = 1'b0; crc_m = 32'hFFFFFFFF;
        tick(); tick();
        chk("rst_clr", a_clr, 1);
        chk("rst_outs", {a_data, a_vld, a_done, a_ok, a_lerr, a_abort, a_len}, 0);
        wb_rst_i = 1'b0;
        tick();
        chk("idle_clr", a_clr, 1);
        rx_bit_i = 1'b1; #1;
        chk("din_1", a_din, 1);
        rx_bit_i = 1'b0; #1;
        chk("din_0", a_din, 0);

        // good frame
        ba = qa.size(); da = a_done_cnt;
        rx_sof_i = 1'b1; crc_m = 32'hFFFFFFFF; tick(); rx_sof_i = 1'b0;
        chk("sof_clr_fall", a_clr, 0);
        tick();
        send5(40'h01020304A5);
        send_crc(crc_m);
        chk("good_residue", crc32_par_i, 32'hC704DD7B);
        eof();
        chk("good_done", a_done, 1);
        chk("good_status", {a_ok, a_lerr, a_abort}, 3'b100);
        chk("good_len", a_len, 5);
        tick();
        chk("good_done_1cyc", a_done, 0);
        chk("good_ok_held", a_ok, 1);
        chk("good_nbytes", qa.size() - ba, 5);
        chk("good_bytes", pack(0, ba, 5), 64'h01020304A5);
        chk("good_ndone", a_done_cnt - da, 1);

        // corrupted payload, original CRC
        ba = qa.size();
        good_r = crc_of5(40'h01020304A5);
        sof();
        send5(40'h010A0304A5);
        send_crc(good_r);
        eof();
        chk("bad_status", {a_ok, a_lerr, a_abort}, 3'b000);
        chk("bad_len", a_len, 5);
        tick();
        chk("bad_bytes", pack(0, ba, 5), 64'h010A0304A5);

        // misaligned: 3 trailing bits
        sof();
        send5(40'h01020304A5);
        send_crc(crc_m);
        send_bit(1); send_bit(0); send_bit(1);
        eof();
        chk("mis_status", {a_ok, a_lerr, a_abort}, 3'b010);
        tick();

        // short frame
        ba = qa.size();
        sof();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        eof();
        chk("short_status", {a_ok, a_lerr, a_abort}, 3'b010);
        chk("short_len", a_len, 0);
        tick();
        chk("short_nbytes", qa.size() - ba, 0);

        // overlong on MAX_BYTES=8 instance
        bb = qb.size(); db = b_done_cnt;
        sof();
        for (int k = 0; k < 8; k++) send_byte(8'h10 + 8'(k));
        chk("long_nodone8", b_done_cnt - db, 0);
        send_byte(8'h18);
        chk("long_done9", b_done_cnt - db, 1);
        chk("long_lerr9", b_lerr, 1);
        send_byte(8'h19); send_byte(8'h1A); send_byte(8'h1B);
        eof();
        tick();
        chk("long_ndone", b_done_cnt - db, 1);
        chk("long_status", {b_ok, b_lerr, b_abort}, 3'b010);
        chk("long_len", b_len, 4);
        chk("long_bytes", pack(1, bb, 4), 64'h10111213);
        chk("long_nbytes", qb.size() - bb, 4);

        // abort after 6 bytes
        ba = qa.size();
        sof();
        for (int k = 0; k < 6; k++) send_byte(8'h20 + 8'(k));
        rx_abort_i = 1'b1; tick(); rx_abort_i = 1'b0;
        chk("abort_done", a_done, 1);
        chk("abort_status", {a_ok, a_lerr, a_abort}, 3'b001);
        chk("abort_len", a_len, 2);
        tick();
        chk("abort_bytes", pack(0, ba, 2), 64'h2021);
        chk("abort_nbytes", qa.size() - ba, 2);

        // restart by second sof
        ba = qa.size(); da = a_done_cnt;
        sof();
        send_byte(8'h30); send_byte(8'h31); send_byte(8'h32);
        rx_sof_i = 1'b1; crc_m = 32'hFFFFFFFF; tick(); rx_sof_i = 1'b0;
        chk("restart_clr_hi", a_clr, 1);
        chk("restart_nodone", a_done, 0);
        tick();
        chk("restart_clr_lo", a_clr, 0);
        send5(40'h01020304A5);
        send_crc(crc_m);
        eof();
        chk("restart_status", {a_ok, a_lerr, a_abort}, 3'b100);
        tick();
        chk("restart_ndone", a_done_cnt - da, 1);
        chk("restart_bytes", pack(0, ba, 5), 64'h01020304A5);
        chk("restart_nbytes", qa.size() - ba, 5);

        // reset mid-byte
        ba = qa.size(); da = a_done_cnt;
        sof();
        send_byte(8'h55);
        send_bit(1); send_bit(1); send_bit(0);
        wb_rst_i = 1'b1; tick(); wb_rst_i = 1'b0;
        chk("mrst_clr", a_clr, 1);
        chk("mrst_outs", {a_data, a_vld, a_done, a_ok, a_lerr, a_abort, a_len}, 0);
        tick();
        chk("mrst_nothing", {32'(qa.size() - ba), 32'(a_done_cnt - da)}, 0);
        sof();
        send5(40'h01020304A5);
        send_crc(crc_m);
        eof();
        chk("post_rst_status", {a_ok, a_lerr, a_abort}, 3'b100);
        chk("post_rst_len", a_len, 5);
        tick();
        chk("post_rst_bytes", pack(0, ba, 5), 64'h01020304A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irda_fir_rx_deframer.md
Name: irda_fir_rx_deframer

Overview:
FIR (4 Mb/s) receive deframer. It sits between the 4PPM symbol decoder, which delivers serial bits qualified by fir_rx4_enable, and the receive FIFO/Wishbone side. It also drives and reads the serial CRC-32 checker:
- drives the checker's clear input and data input (checker's crcndata tied 0);
- reads the checker's 32-bit register to judge the frame.

It packs bits LSB-first into bytes and withholds the trailing 4 CRC bytes through a 4-byte delay line. At frame end it reports length, CRC status and framing errors.

Parameters:
MAX_BYTES, 2050, maximum bytes per frame including the 4 CRC bytes; exceeding it is a length error.
LEN_W, 12, width of the payload byte counter and rx_len_o.
CRC_RESIDUE, 32'hC704DD7B, required CRC register value after a good frame (non-reflected residue, data plus complemented CRC).

Ports:
clk  in  1  system clock
wb_rst_i  in  1  synchronous active-high reset
fir_rx4_enable  in  1  bit strobe from 4PPM decoder; one strobe per decoded bit
rx_bit_i  in  1  decoded data bit, valid when fir_rx4_enable=1
rx_sof_i  in  1  one-cycle pulse: start flag detected, first data bit follows
rx_eof_i  in  1  one-cycle pulse: stop flag detected, no more data bits
rx_abort_i  in  1  one-cycle pulse: code violation / carrier loss
crc32_par_i  in  32  CRC checker register contents
crc_clr_o  out  1  to checker clrcrc; high = reload 0xFFFFFFFF on next strobe
crc_din_o  out  1  to checker data input; combinational copy of rx_bit_i
rx_data_o  out  8  payload byte
rx_data_valid_o  out  1  one-cycle strobe, rx_data_o valid
rx_done_o  out  1  one-cycle pulse, frame finished; status outputs valid
rx_crc_ok_o  out  1  frame CRC matched; held until next rx_sof_i
rx_len_err_o  out  1  misaligned, short (<4 bytes) or overlong frame; held
rx_abort_o  out  1  frame aborted; held
rx_len_o  out  LEN_W  payload byte count, excluding CRC; held

Behaviour:
- Clock clk only. Reset wb_rst_i is synchronous, active-high; all state updates on posedge clk.
- Reset values:
  - state=IDLE, crc_clr_o=1;
  - rx_data_o=0, rx_data_valid_o=0, rx_done_o=0;
  - all status outputs=0; rx_len_o=0; counters and delay line cleared.
- States:
  - IDLE: crc_clr_o=1; bit strobes ignored; rx_sof_i -> RECV.
  - RECV: crc_clr_o=0; each strobe shifts rx_bit_i into bit 7 of the shift register (shift right, LSB-first) and increments bit_cnt[2:0].
  - DONE: one cycle; rx_done_o=1; -> IDLE.
- rx_sof_i clears status outputs, bit_cnt, delay-line count dl_cnt (0..4) and rx_len_o.
- crc_clr_o falls the cycle after rx_sof_i. The checker has therefore been clearing on every preamble strobe and starts from all-ones on the first data bit.
- Byte completion happens on the strobe where bit_cnt wraps 7->0:
  - dl_cnt<4: byte enters the delay line, dl_cnt++.
  - dl_cnt==4: oldest byte is registered to rx_data_o with rx_data_valid_o=1 on the next cycle, new byte enters, rx_len_o++.
  - Latency: payload byte n appears 1 cycle after the strobe completing byte n+4.
- Total byte count (rx_len_o + dl_cnt) would exceed MAX_BYTES: rx_len_err_o=1, -> DONE; remaining bits ignored.
- rx_eof_i in RECV -> DONE, and the evaluation is registered into the DONE cycle:
  - rx_len_err_o = (bit_cnt!=0) | (dl_cnt<4).
  - rx_crc_ok_o = !rx_len_err_o & (crc32_par_i==CRC_RESIDUE).
  - The 4 delay-line bytes are discarded and never output.
- rx_eof_i must follow the last data strobe by at least 1 cycle. A strobe in the same cycle as rx_eof_i is ignored.
- rx_abort_i in RECV -> DONE with rx_abort_o=1, crc_ok=0, len_err=0. rx_abort_i in IDLE/DONE is ignored.
- rx_sof_i in RECV restarts the frame: counters and delay line cleared, no rx_done_o, crc_clr_o pulses high 1 cycle.
- Same-cycle priority: wb_rst_i > rx_abort_i > rx_eof_i > rx_sof_i > strobe.
- rx_len_o saturates at 2^LEN_W-1 and never wraps.
- Reset mid-frame returns to IDLE immediately; no done pulse, no partial byte output.

Test Plan:
- Good frame: sof, payload 8'h01,8'h02,8'h03,8'h04,8'hA5 + 4 CRC bytes from model, LSB-first, one strobe every 2 cycles, eof -> exactly 5 valid strobes with 01,02,03,04,A5 in order; done pulse; crc_ok=1, len=5, len_err=0, abort=0; crc32_par_i==C704DD7B at eof.
- Same frame with bit 3 of byte 2 flipped -> 5 bytes out (02 becomes 0A); crc_ok=0, len_err=0.
- Misalignment: good frame plus 3 extra bits -> len_err=1, crc_ok=0. Short frame: sof, 3 bytes, eof -> no valid strobes, len=0, len_err=1.
- Overlong: MAX_BYTES=8, 12 bytes sent -> 4 payload bytes out, then done on the strobe completing the 9th byte; len_err=1, later bits and eof ignored.
- Abort after 6 bytes -> 2 bytes out, done, abort=1, crc_ok=0. Second sof at byte 3 -> no done, crc_clr_o 1-cycle pulse, the next frame is decoded correctly.
- wb_rst_i asserted mid-byte and held 1 cycle -> all outputs at reset values next cycle, crc_clr_o=1. Next good frame passes with crc_ok=1.
